// File: rtl/pic_inta_controller.sv
// ============================================================================
// pic_inta_controller : 8259A-style INTA sequencer with ISR, priority and EOI
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module pic_inta_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_accepted,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       auto_rotate,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic       INT,
  output logic [7:0] ISR,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       irr_clear,
  output logic [2:0] irr_clear_level,
  output logic [2:0] lowest_prio,
  output logic       spurious
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_inta_n_q;
  logic [2:0] r_cur_level;

  logic       w_fall;
  logic       w_rise;
  logic       w_win_valid;
  logic [2:0] w_win_level;
  logic [2:0] w_win_rank;
  logic       w_isr_any;
  logic [2:0] w_isr_top_level;
  logic [2:0] w_isr_top_rank;
  logic       w_eligible;
  logic       w_ack1_set;
  logic       w_ack2_done;
  logic       w_aeoi_hit;
  logic       w_eoi_hit;
  logic [2:0] w_eoi_target;
  logic [7:0] w_set;
  logic [7:0] w_clr_aeoi;
  logic [7:0] w_clr_eoi;
  logic [7:0] w_isr_next;

  // Level sitting at a given rank: rank 0 is the level just above lowest_prio.
  function automatic logic [2:0] level_of_rank(input logic [2:0] lowest,
                                               input logic [2:0] rank);
    return lowest + 3'd1 + rank;
  endfunction

  // Scan from lowest to highest rank so the last hit is the best one.
  always_comb begin
    w_win_valid     = 1'b0;
    w_win_level     = 3'd0;
    w_win_rank      = 3'd0;
    w_isr_any       = 1'b0;
    w_isr_top_level = 3'd0;
    w_isr_top_rank  = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (irq_accepted[level_of_rank(lowest_prio, 3'(r))]) begin
        w_win_valid = 1'b1;
        w_win_level = level_of_rank(lowest_prio, 3'(r));
        w_win_rank  = 3'(r);
      end
      if (ISR[level_of_rank(lowest_prio, 3'(r))]) begin
        w_isr_any       = 1'b1;
        w_isr_top_level = level_of_rank(lowest_prio, 3'(r));
        w_isr_top_rank  = 3'(r);
      end
    end
  end

  assign w_eligible  = w_win_valid & (~w_isr_any | (w_win_rank < w_isr_top_rank));
  assign w_fall      = r_inta_n_q & ~inta_n;
  assign w_rise      = ~r_inta_n_q & inta_n;

  assign w_ack1_set  = (r_state == IDLE) & w_fall & w_eligible;
  assign w_ack2_done = (r_state == ACK2) & w_rise;
  assign w_aeoi_hit  = w_ack2_done & aeoi & ~spurious;

  // Non-specific EOI with nothing in service targets no level at all.
  assign w_eoi_hit    = eoi_cmd & (eoi_specific | w_isr_any);
  assign w_eoi_target = eoi_specific ? eoi_level : w_isr_top_level;

  assign w_set      = w_ack1_set ? (8'd1 << w_win_level)  : 8'd0;
  assign w_clr_aeoi = w_aeoi_hit ? (8'd1 << r_cur_level)  : 8'd0;
  assign w_clr_eoi  = w_eoi_hit  ? (8'd1 << w_eoi_target) : 8'd0;
  assign w_isr_next = (ISR & ~w_clr_eoi & ~w_clr_aeoi) | w_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_inta_n_q      <= 1'b1;
      r_cur_level     <= 3'd0;
      INT             <= 1'b0;
      ISR             <= 8'd0;
      data_out        <= 8'd0;
      data_oe         <= 1'b0;
      irr_clear       <= 1'b0;
      irr_clear_level <= 3'd0;
      lowest_prio     <= 3'd7;
      spurious        <= 1'b0;
    end else begin
      r_inta_n_q <= inta_n;
      ISR        <= w_isr_next;
      irr_clear  <= 1'b0;
      INT        <= (r_state == IDLE) & w_eligible & ~w_fall;

      if (w_eoi_hit & eoi_rotate) begin
        lowest_prio <= w_eoi_target;
      end else if (w_aeoi_hit & auto_rotate) begin
        lowest_prio <= r_cur_level;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state <= ACK1;
            if (w_eligible) begin
              r_cur_level     <= w_win_level;
              irr_clear       <= 1'b1;
              irr_clear_level <= w_win_level;
              spurious        <= 1'b0;
            end else begin
              r_cur_level <= 3'd7;
              spurious    <= 1'b1;
            end
          end
        end
        ACK1: begin
          if (w_rise) r_state <= GAP;
        end
        GAP: begin
          if (w_fall) begin
            r_state  <= ACK2;
            data_oe  <= 1'b1;
            data_out <= {vector_base, r_cur_level};
          end
        end
        ACK2: begin
          if (w_rise) begin
            r_state  <= IDLE;
            data_oe  <= 1'b0;
            data_out <= 8'd0;
            spurious <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pic_inta_controller.sv
// ============================================================================
// tb_pic_inta_controller : directed plus randomized checks against a
// cycle-level reference model of the INTA/ISR/EOI behaviour.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pic_inta_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_accepted = 8'd0;
  logic       inta_n = 1'b1;
  logic [4:0] vector_base = 5'd0;
  logic       aeoi = 1'b0;
  logic       auto_rotate = 1'b0;
  logic       eoi_cmd = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       eoi_rotate = 1'b0;

  logic       INT;
  logic [7:0] ISR;
  logic [7:0] data_out;
  logic       data_oe;
  logic       irr_clear;
  logic [2:0] irr_clear_level;
  logic [2:0] lowest_prio;
  logic       spurious;

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_q, m_phase, m_low, m_cur, m_clrlvl;
  logic [7:0] m_isr, m_dout;
  logic       m_spur, m_int, m_clr, m_oe;

  pic_inta_controller dut (
    .clk(clk), .reset(reset), .irq_accepted(irq_accepted), .inta_n(inta_n),
    .vector_base(vector_base), .aeoi(aeoi), .auto_rotate(auto_rotate),
    .eoi_cmd(eoi_cmd), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .eoi_rotate(eoi_rotate), .INT(INT), .ISR(ISR), .data_out(data_out),
    .data_oe(data_oe), .irr_clear(irr_clear), .irr_clear_level(irr_clear_level),
    .lowest_prio(lowest_prio), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rank_of(input int p, input int low);
    return (p - low - 1 + 16) % 8;
  endfunction

  task automatic model_step();
    int best, brank, itop, irank, lvl, newlow;
    bit fall, rise, elig, hit, old_spur;
    logic [7:0] set_m, clr_m;
    if (reset) begin
      m_q = 1; m_phase = 0; m_isr = 8'd0; m_low = 7; m_cur = 0; m_spur = 1'b0;
      m_int = 1'b0; m_clr = 1'b0; m_clrlvl = 0; m_oe = 1'b0; m_dout = 8'd0;
      return;
    end
    fall = (m_q == 1) && (inta_n == 1'b0);
    rise = (m_q == 0) && (inta_n == 1'b1);
    best = -1; brank = 8; itop = -1; irank = 8;
    for (int p = 0; p < 8; p++) begin
      if (irq_accepted[p] && rank_of(p, m_low) < brank) begin
        best = p; brank = rank_of(p, m_low);
      end
      if (m_isr[p] && rank_of(p, m_low) < irank) begin
        itop = p; irank = rank_of(p, m_low);
      end
    end
    elig = (best >= 0) && (m_isr == 8'd0 || brank < irank);
    set_m = 8'd0; clr_m = 8'd0; newlow = m_low; old_spur = m_spur;
    m_int = (m_phase == 0) && elig && !fall;
    m_clr = 1'b0;
    if (m_phase == 0 && fall) begin
      m_phase = 1;
      if (elig) begin
        m_cur = best; set_m = 8'(1 << best); m_clr = 1'b1; m_clrlvl = best; m_spur = 1'b0;
      end else begin
        m_cur = 7; m_spur = 1'b1;
      end
    end else if (m_phase == 1 && rise) begin
      m_phase = 2;
    end else if (m_phase == 2 && fall) begin
      m_phase = 3; m_oe = 1'b1; m_dout = {vector_base, 3'(m_cur)};
    end else if (m_phase == 3 && rise) begin
      m_phase = 0; m_oe = 1'b0; m_dout = 8'd0; m_spur = 1'b0;
      if (aeoi && !old_spur) begin
        clr_m = clr_m | 8'(1 << m_cur);
        if (auto_rotate) newlow = m_cur;
      end
    end
    if (eoi_cmd) begin
      hit = 1'b0; lvl = 0;
      if (eoi_specific) begin
        hit = 1'b1; lvl = int'(eoi_level);
      end else if (itop >= 0) begin
        hit = 1'b1; lvl = itop;
      end
      if (hit) begin
        clr_m = clr_m | 8'(1 << lvl);
        if (eoi_rotate) newlow = lvl;
      end
    end
    m_isr = (m_isr & ~clr_m) | set_m;
    m_low = newlow;
    m_q   = int'(inta_n);
  endtask

  task automatic compare_all();
    check_val("INT", 8'(INT), 8'(m_int));
    check_val("ISR", ISR, m_isr);
    check_val("data_oe", 8'(data_oe), 8'(m_oe));
    check_val("irr_clear", 8'(irr_clear), 8'(m_clr));
    check_val("lowest_prio", 8'(lowest_prio), 8'(m_low));
    check_val("spurious", 8'(spurious), 8'(m_spur));
    if (m_oe) check_val("data_out", data_out, m_dout);
    if (m_clr) check_val("irr_clear_level", 8'(irr_clear_level), 8'(m_clrlvl));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_values();
    check_val("rst_INT", 8'(INT), 8'd0);
    check_val("rst_ISR", ISR, 8'd0);
    check_val("rst_data_out", data_out, 8'd0);
    check_val("rst_data_oe", 8'(data_oe), 8'd0);
    check_val("rst_irr_clear", 8'(irr_clear), 8'd0);
    check_val("rst_irr_clear_level", 8'(irr_clear_level), 8'd0);
    check_val("rst_lowest_prio", 8'(lowest_prio), 8'd7);
    check_val("rst_spurious", 8'(spurious), 8'd0);
  endtask

  // first INTA pulse; the IRR bit is dropped once the controller asks for it
  task automatic first_pulse();
    inta_n = 1'b0;
    tick();
    check_val("int_low_ack1", 8'(INT), 8'd0);
    if (m_clr) irq_accepted[m_clrlvl] = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    check_val("int_low_gap", 8'(INT), 8'd0);
    tick();
  endtask

  task automatic second_pulse(input logic [7:0] vec);
    inta_n = 1'b0;
    tick();
    check_val("vector", data_out, vec);
    check_val("oe_ack2", 8'(data_oe), 8'd1);
    tick();
    inta_n = 1'b1;
    tick();
    check_val("oe_after", 8'(data_oe), 8'd0);
    tick();
  endtask

  task automatic ack(input logic [7:0] vec);
    first_pulse();
    second_pulse(vec);
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
    tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
  endtask

  initial begin
    // basic acknowledge
    do_reset();
    check_reset_values();
    vector_base = 5'b01000;
    irq_accepted = 8'h08;
    tick(); tick();
    check_val("basic_INT", 8'(INT), 8'd1);
    ack(8'h43);
    check_val("basic_ISR", ISR, 8'h08);

    // nesting
    do_reset();
    irq_accepted = 8'h02;
    tick();
    ack(8'h41);
    irq_accepted = 8'h10;
    tick(); tick();
    check_val("nest_blocked", 8'(INT), 8'd0);
    irq_accepted = 8'h11;
    tick(); tick();
    check_val("nest_INT", 8'(INT), 8'd1);
    ack(8'h40);
    check_val("nest_ISR", ISR, 8'h03);

    // AEOI with rotation
    do_reset();
    aeoi = 1'b1; auto_rotate = 1'b1;
    irq_accepted = 8'h04;
    tick();
    ack(8'h42);
    check_val("aeoi_ISR", ISR, 8'h00);
    check_val("aeoi_low", 8'(lowest_prio), 8'd2);
    irq_accepted = 8'h09;
    tick(); tick();
    ack(8'h43);
    check_val("aeoi_low2", 8'(lowest_prio), 8'd3);
    aeoi = 1'b0; auto_rotate = 1'b0;

    // EOI flavours
    do_reset();
    irq_accepted = 8'h08;
    tick();
    ack(8'h43);
    irq_accepted = 8'h02;
    tick();
    ack(8'h41);
    check_val("eoi_pre", ISR, 8'h0A);
    eoi(1'b0, 3'd0, 1'b0);
    check_val("eoi_ns", ISR, 8'h08);
    eoi(1'b1, 3'd3, 1'b1);
    check_val("eoi_sp", ISR, 8'h00);
    check_val("eoi_rot", 8'(lowest_prio), 8'd3);
    eoi(1'b0, 3'd0, 1'b1);
    check_val("eoi_noop_isr", ISR, 8'h00);
    check_val("eoi_noop_low", 8'(lowest_prio), 8'd3);

    // spurious acknowledge
    do_reset();
    irq_accepted = 8'h00;
    tick();
    inta_n = 1'b0;
    tick();
    check_val("spur_flag", 8'(spurious), 8'd1);
    check_val("spur_noclr", 8'(irr_clear), 8'd0);
    check_val("spur_isr", ISR, 8'h00);
    tick();
    inta_n = 1'b1;
    tick(); tick();
    second_pulse(8'h47);
    check_val("spur_isr_end", ISR, 8'h00);

    // reset between the two pulses
    do_reset();
    irq_accepted = 8'h20;
    tick();
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    irq_accepted = 8'h20;
    tick(); tick();
    ack(8'h45);

    // randomized traffic
    do_reset();
    vector_base = 5'($urandom);
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) irq_accepted = 8'($urandom);
      if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
      if ($urandom_range(0, 31) == 0) aeoi = ~aeoi;
      if ($urandom_range(0, 31) == 0) auto_rotate = ~auto_rotate;
      eoi_cmd      = ($urandom_range(0, 7) == 0);
      eoi_specific = 1'($urandom);
      eoi_level    = 3'($urandom);
      eoi_rotate   = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
